// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF input synchroniser, oversampled bit timing,
// false-start rejection, framing/parity/overrun flags and a valid/ready output.
// Optional build macro UART_RX_MAJORITY_EN: each bit value is the 2-of-3 majority
// of the samples at MID-1, MID and MID+1, with the decision taken at MID+1.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9_600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned MID     = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned DEC     = MID + 1;
`else
    localparam int unsigned DEC     = MID;
`endif
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W   = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_DEC       = SMP_W'(DEC);
    localparam logic [SMP_W-1:0] SMP_LAST      = SMP_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       BIT_LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q;
    logic [DIV_W-1:0]     div_q;
    logic [1:0]           sync_q;
    logic [SMP_W-1:0]     samp_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_bad_q, parity_bad_q;
    logic                 armed_q, done_q;
    logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 tick, rxd_s, bit_val;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rxd_i};
    end
    assign rxd_s = sync_q[1];

    // Free-running divider producing one sample tick every DIV clocks.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)   div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 1'b1;
    end
    assign tick = (div_q == DIV_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Keeps the two previous tick samples so the vote at MID+1 sees MID-1 and MID.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)   hist_q <= 2'b11;
        else if (tick) hist_q <= {hist_q[0], rxd_s};
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s) | (hist_q[0] & rxd_s);
`else
    assign bit_val = rxd_s;
`endif

    // Frame FSM; all progress is gated by the sample tick.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            samp_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            frame_bad_q  <= 1'b0;
            parity_bad_q <= 1'b0;
            armed_q      <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        samp_q <= '0;
                        // After a break frame the line must go high before a new start.
                        if (rxd_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q      <= StStart;
                            frame_bad_q  <= 1'b0;
                            parity_bad_q <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (samp_q == SMP_DEC && bit_val) begin
                            state_q <= StIdle;
                            samp_q  <= '0;
                        end else if (samp_q == SMP_LAST) begin
                            state_q <= StData;
                            samp_q  <= '0;
                            bit_q   <= '0;
                        end else begin
                            samp_q <= samp_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (samp_q == SMP_DEC) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        if (samp_q == SMP_LAST) begin
                            samp_q <= '0;
                            if (bit_q == BIT_LAST_DATA) begin
                                bit_q   <= '0;
                                state_q <= (PARITY != 0) ? StParity : StStop;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            samp_q <= samp_q + 1'b1;
                        end
                    end
                    StParity: begin
                        if (samp_q == SMP_DEC) begin
                            parity_bad_q <= ((^shift_q) ^ bit_val) != (PARITY == 1);
                        end
                        if (samp_q == SMP_LAST) begin
                            state_q <= StStop;
                            samp_q  <= '0;
                        end else begin
                            samp_q <= samp_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (samp_q == SMP_DEC) begin
                            frame_bad_q <= frame_bad_q | ~bit_val;
                            if (bit_q == BIT_LAST_STOP) begin
                                // Complete mid stop bit so the next start edge is not missed.
                                state_q <= StIdle;
                                samp_q  <= '0;
                                done_q  <= 1'b1;
                                armed_q <= bit_val;
                            end else begin
                                samp_q <= samp_q + 1'b1;
                            end
                        end else if (samp_q == SMP_LAST) begin
                            samp_q <= '0;
                            bit_q  <= bit_q + 1'b1;
                        end else begin
                            samp_q <= samp_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (done_q) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_q    <= shift_q;
                frame_err_q  <= frame_bad_q;
                parity_err_q <= parity_bad_q;
                rx_valid_q   <= 1'b1;
                overrun_q    <= 1'b0;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end
    end

    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7E1 instance, 16 clocks per bit.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rxd_p = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, perr, ovr, busy;
    logic [6:0] data_p;
    logic       valid_p, ferr_p, perr_p, ovr_p, busy_p;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut (
        .clk_i(clk), .reset_i(reset), .rxd_i(rxd), .rx_data_o(data), .rx_valid_o(valid),
        .rx_ready_i(rdy), .frame_err_o(ferr), .parity_err_o(perr), .overrun_o(ovr),
        .busy_o(busy)
    );

    uart_rx_param #(
        .CLK_FREQ(16_000_000), .BAUD(1_000_000), .OVERSAMPLE(16),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .clk_i(clk), .reset_i(reset), .rxd_i(rxd_p), .rx_data_o(data_p), .rx_valid_o(valid_p),
        .rx_ready_i(rdy), .frame_err_o(ferr_p), .parity_err_o(perr_p), .overrun_o(ovr_p),
        .busy_o(busy_p)
    );

    task automatic send_bit(input bit use_p, input logic v);
        if (use_p) rxd_p = v;
        else       rxd = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit use_p, input logic [8:0] d, input int nbits,
                              input bit has_par, input logic par, input logic stop);
        send_bit(use_p, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(use_p, d[i]);
        if (has_par) send_bit(use_p, par);
        send_bit(use_p, stop);
        if (use_p) rxd_p = 1'b1;
        else       rxd = 1'b1;
    endtask

    task automatic pulse_ready();
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", data); end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL rst_ferr: got %b want 0", ferr); end
        n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL rst_perr: got %b want 0", perr); end
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL rst_ovr: got %b want 0", ovr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_8n1();
        int k = 0;
        send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
        while (valid !== 1'b1 && k < 32) begin @(posedge clk); #1; k++; end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL a5_valid: got %b want 1", valid); end
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL a5_data: got %h want a5", data); end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL a5_ferr: got %b want 0", ferr); end
        n_cmp++; if (perr !== 1'b0) begin n_bad++; $display("FAIL a5_perr: got %b want 0", perr); end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL a5_hold: got %b want 1", valid); end
        pulse_ready();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL a5_ack: got %b want 0", valid); end
    endtask

    task automatic test_parity();
        int k = 0;
        // 0x3C has four ones, so the even-parity bit is 0; send 1 first.
        send_frame(1'b1, 9'h03C, 7, 1'b1, 1'b1, 1'b1);
        while (valid_p !== 1'b1 && k < 32) begin @(posedge clk); #1; k++; end
        n_cmp++; if (valid_p !== 1'b1) begin n_bad++; $display("FAIL par1_valid: got %b want 1", valid_p); end
        n_cmp++; if (data_p !== 7'h3C) begin n_bad++; $display("FAIL par1_data: got %h want 3c", data_p); end
        n_cmp++; if (perr_p !== 1'b1) begin n_bad++; $display("FAIL par1_perr: got %b want 1", perr_p); end
        n_cmp++; if (ferr_p !== 1'b0) begin n_bad++; $display("FAIL par1_ferr: got %b want 0", ferr_p); end
        pulse_ready();
        n_cmp++; if (perr_p !== 1'b0) begin n_bad++; $display("FAIL par_ack: got %b want 0", perr_p); end
        send_frame(1'b1, 9'h03C, 7, 1'b1, 1'b0, 1'b1);
        k = 0;
        while (valid_p !== 1'b1 && k < 32) begin @(posedge clk); #1; k++; end
        n_cmp++; if (valid_p !== 1'b1) begin n_bad++; $display("FAIL par2_valid: got %b want 1", valid_p); end
        n_cmp++; if (data_p !== 7'h3C) begin n_bad++; $display("FAIL par2_data: got %h want 3c", data_p); end
        n_cmp++; if (perr_p !== 1'b0) begin n_bad++; $display("FAIL par2_perr: got %b want 0", perr_p); end
        pulse_ready();
    endtask

    task automatic test_frame_err();
        int k = 0;
        send_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b0);
        while (valid !== 1'b1 && k < 32) begin @(posedge clk); #1; k++; end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ferr_valid: got %b want 1", valid); end
        n_cmp++; if (data !== 8'h55) begin n_bad++; $display("FAIL ferr_data: got %h want 55", data); end
        n_cmp++; if (ferr !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", ferr); end
        pulse_ready();
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL ferr_ack: got %b want 0", ferr); end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL b2b_ovr_first: got %b want 0", ovr); end
        send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", valid); end
        n_cmp++; if (data !== 8'h11) begin n_bad++; $display("FAIL b2b_data: got %h want 11", data); end
        n_cmp++; if (ovr !== 1'b1) begin n_bad++; $display("FAIL b2b_ovr: got %b want 1", ovr); end
        pulse_ready();
        n_cmp++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL b2b_ovr_ack: got %b want 0", ovr); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_ack: got %b want 0", valid); end
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL glitch_valid: got %b want 0", valid); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        logic [7:0] d;
        d = 8'h81;
        send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (data !== 8'h5A) begin n_bad++; $display("FAIL rmid_pre_data: got %h want 5a", data); end
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, d[i]);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", valid); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL rmid_data: got %h want 00", data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        rxd = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_valid: got %b want 0", valid); end
        send_frame(1'b0, 9'h081, 8, 1'b0, 1'b0, 1'b1);
        while (valid !== 1'b1 && k < 32) begin @(posedge clk); #1; k++; end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL r81_valid: got %b want 1", valid); end
        n_cmp++; if (data !== 8'h81) begin n_bad++; $display("FAIL r81_data: got %h want 81", data); end
        pulse_ready();
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic send_glitch_bit(input logic v);
        rxd = v;
        repeat (8) @(posedge clk);
        #1;
        rxd = ~v;
        @(posedge clk);
        #1;
        rxd = v;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic test_majority();
        int k = 0;
        logic [7:0] d;
        d = 8'hA5;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_glitch_bit(d[i]);
        send_bit(1'b0, 1'b1);
        while (valid !== 1'b1 && k < 32) begin @(posedge clk); #1; k++; end
        n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL maj_valid: got %b want 1", valid); end
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL maj_data: got %h want a5", data); end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL maj_ferr: got %b want 0", ferr); end
        pulse_ready();
    endtask
`endif

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
